// File: rtl/jpeg_buf_pkg.sv
// Shared types and helpers for the JPEG readout buffer: FSM states and byte-lane selection.
package jpeg_buf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2,
    READ    = 2'd3
  } state_e;

  // Byte 0 of a word is the most significant lane.
  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jpeg_buf_ram.sv
// Simple dual-port image RAM: one write port, one synchronous read port (block RAM friendly).
module jpeg_buf_ram #(
  parameter int DEPTH = 4096,
  parameter int WW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [WW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [WW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/jpeg_readout_buffer.sv
// Captures encoder words into image RAM and replays the stored image as a valid/ready byte stream.
module jpeg_readout_buffer
  import jpeg_buf_pkg::*;
#(
  parameter int BUFFER_BYTES = 16384,
  parameter int AW           = $clog2(BUFFER_BYTES)
) (
  input  logic        clock_pixel_in,
  input  logic        reset_pixel_in,
  input  logic        capture_start_in,
  input  logic [31:0] data_in,
  input  logic [15:0] address_in,
  input  logic        data_valid_in,
  input  logic        image_valid_in,
  output logic        image_ready_out,
  output logic [15:0] image_size_out,
  output logic        overflow_out,
  input  logic        rd_start_in,
  output logic [7:0]  rd_byte_out,
  output logic        rd_valid_out,
  input  logic        rd_ready_in,
  output logic        rd_done_out
);

  localparam int          PW  = AW + 1;
  localparam int          WW  = AW - 2;
  localparam logic [16:0] LIM = 17'(BUFFER_BYTES);

  state_e        state_q, state_d;
  logic [PW-1:0] hwm_q, hwm_d, size_q, size_d, ptr_q, ptr_d, ptr_inc;
  logic          ready_q, ready_d, ovf_q, ovf_d;
  logic          pend_q, pend_d, vld_q, vld_d, done_q, done_d;
  logic [7:0]    byte_q, byte_d;
  logic [16:0]   wr_end, wr_sat;
  logic          wr_fit, we, adv;
  logic [WW-1:0] raddr;
  logic [31:0]   rdata;

  jpeg_buf_ram #(.DEPTH(BUFFER_BYTES / 4), .WW(WW)) u_ram (
    .clk   (clock_pixel_in),
    .we    (we),
    .waddr (address_in[AW-1:2]),
    .wdata (data_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  // pend_q: ptr_q names a byte whose word sits on rdata and still needs to reach the output register.
  // Without an advance the read address is held, so rdata keeps that word through a stall.
  always_comb begin
    wr_end  = {1'b0, address_in} + 17'd4;
    wr_fit  = (wr_end <= LIM);
    wr_sat  = wr_fit ? wr_end : LIM;
    ptr_inc = ptr_q + PW'(1);
    adv     = pend_q && (!vld_q || rd_ready_in);

    state_d = state_q;
    hwm_d   = hwm_q;
    size_d  = size_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
    vld_d   = vld_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    we      = 1'b0;
    raddr   = ptr_q[AW-1:2];

    case (state_q)
      IDLE: begin
        hwm_d   = '0;
        ovf_d   = 1'b0;
        ready_d = 1'b0;
      end
      CAPTURE: begin
        if (data_valid_in) begin
          we    = wr_fit;
          ovf_d = ovf_q | ~wr_fit;
          if (PW'(wr_sat) > hwm_q) hwm_d = PW'(wr_sat);
        end else if (image_valid_in) begin
          size_d  = hwm_q;
          ready_d = 1'b1;
          state_d = READY;
        end
      end
      READY: begin
        raddr = '0;
        if (rd_start_in) begin
          if (size_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = READ;
            ptr_d   = '0;
            pend_d  = 1'b1;
          end
        end
      end
      default: begin
        if (adv) begin
          byte_d = byte_lane(rdata, ptr_q[1:0]);
          vld_d  = 1'b1;
          ptr_d  = ptr_inc;
          pend_d = (ptr_inc < size_q);
          raddr  = ptr_inc[AW-1:2];
        end else if (vld_q && rd_ready_in) begin
          vld_d   = 1'b0;
          done_d  = 1'b1;
          state_d = READY;
        end
      end
    endcase

    if (capture_start_in) begin
      state_d = CAPTURE;
      hwm_d   = '0;
      size_d  = '0;
      ovf_d   = 1'b0;
      ready_d = 1'b0;
      vld_d   = 1'b0;
      pend_d  = 1'b0;
      done_d  = 1'b0;
      we      = 1'b0;
    end
  end

  always_ff @(posedge clock_pixel_in or posedge reset_pixel_in) begin
    if (reset_pixel_in) begin
      state_q <= IDLE;
      hwm_q   <= '0;
      size_q  <= '0;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      vld_q   <= 1'b0;
      byte_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hwm_q   <= hwm_d;
      size_q  <= size_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
    end
  end

  assign image_ready_out = ready_q;
  assign image_size_out  = 16'(size_q);
  assign overflow_out    = ovf_q;
  assign rd_byte_out     = byte_q;
  assign rd_valid_out    = vld_q;
  assign rd_done_out     = done_q;

endmodule

// File: tb/tb_jpeg_readout_buffer.sv
// Bench for jpeg_readout_buffer: byte-array image model plus directed capture/readout scenarios.
module tb_jpeg_readout_buffer;

  localparam int BB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_start_in, data_valid_in, image_valid_in, rd_start_in, rd_ready_in;
  logic [31:0] data_in;
  logic [15:0] address_in;
  logic        image_ready_out, overflow_out, rd_valid_out, rd_done_out;
  logic [15:0] image_size_out;
  logic [7:0]  rd_byte_out;

  jpeg_readout_buffer #(.BUFFER_BYTES(BB)) dut (
    .clock_pixel_in   (clk),
    .reset_pixel_in   (rst),
    .capture_start_in (capture_start_in),
    .data_in          (data_in),
    .address_in       (address_in),
    .data_valid_in    (data_valid_in),
    .image_valid_in   (image_valid_in),
    .image_ready_out  (image_ready_out),
    .image_size_out   (image_size_out),
    .overflow_out     (overflow_out),
    .rd_start_in      (rd_start_in),
    .rd_byte_out      (rd_byte_out),
    .rd_valid_out     (rd_valid_out),
    .rd_ready_in      (rd_ready_in),
    .rd_done_out      (rd_done_out)
  );

  always #5 clk = ~clk;

  int       n_chk = 0, n_fail = 0;
  bit [7:0] m_mem [BB];
  int       m_hwm = 0, m_size = 0, exp_idx = 0;
  logic     m_ovf = 1'b0, m_cap = 1'b0;
  logic     prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_b = '0;
  logic [7:0] got_q[$], ref_q[$];
  int       hs, first_v, done_at;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Model-driven checks on every cycle outside reset.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      chk("overflow_out", int'(overflow_out), int'(m_ovf));
      if (image_ready_out) chk("image_size_out", int'(image_size_out), m_size);
      if (prev_v && !prev_r) begin
        chk("stall_valid", int'(rd_valid_out), 1);
        chk("stall_byte", int'(rd_byte_out), int'(prev_b));
      end
      if (rd_valid_out && rd_ready_in) begin
        chk("stream_byte", int'(rd_byte_out), (exp_idx < m_size) ? int'(m_mem[exp_idx]) : -1);
        exp_idx++;
      end
      if (rd_done_out) begin
        chk("done_count", exp_idx, m_size);
        chk("done_valid_low", int'(rd_valid_out), 0);
      end
      prev_v = rd_valid_out;
      prev_r = rd_ready_in;
      prev_b = rd_byte_out;
    end
  end

  task automatic cap_start();
    capture_start_in = 1'b1;
    @(posedge clk);
    m_hwm = 0; m_ovf = 1'b0; m_cap = 1'b1;
    #1 capture_start_in = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic iv);
    address_in = 16'(a); data_in = d; data_valid_in = 1'b1; image_valid_in = iv;
    @(posedge clk);
    if (m_cap) begin
      if (a + 4 <= BB) begin
        for (int i = 0; i < 4; i++) m_mem[a + i] = d[31 - 8*i -: 8];
      end else begin
        m_ovf = 1'b1;
      end
      if (((a + 4 > BB) ? BB : a + 4) > m_hwm) m_hwm = (a + 4 > BB) ? BB : a + 4;
    end
    #1 data_valid_in = 1'b0;
  endtask

  task automatic complete();
    m_size = m_hwm;
    image_valid_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (image_ready_out) break;
    end
    chk("ready_timeout", int'(image_ready_out), 1);
    @(posedge clk);
    #1 image_valid_in = 1'b0;
    m_cap = 1'b0;
  endtask

  // mode 0: rd_ready held high; mode 1: rd_ready pattern 1-0-0-1. abort_at>0 exits after that many handshakes.
  task automatic do_read(input int mode, input int abort_at);
    hs = 0; first_v = -1; done_at = -1;
    got_q.delete();
    exp_idx = 0;
    rd_start_in = 1'b1;
    rd_ready_in = (mode == 0);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1 rd_start_in = 1'b0;
      if (mode == 1) rd_ready_in = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
      @(negedge clk);
      if (rd_valid_out && first_v < 0) first_v = k;
      if (rd_valid_out && rd_ready_in) begin
        hs++;
        got_q.push_back(rd_byte_out);
      end
      if (rd_done_out) begin
        done_at = k;
        break;
      end
      if (abort_at > 0 && hs == abort_at) break;
    end
    if (abort_at == 0) chk("read_terminates", int'(done_at > 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    capture_start_in = 1'b0; data_valid_in = 1'b0; image_valid_in = 1'b0;
    rd_start_in = 1'b0; rd_ready_in = 1'b0; data_in = '0; address_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(image_ready_out), 0);
    chk("rst_size", int'(image_size_out), 0);
    chk("rst_ovf", int'(overflow_out), 0);
    chk("rst_valid", int'(rd_valid_out), 0);
    chk("rst_byte", int'(rd_byte_out), 0);
    chk("rst_done", int'(rd_done_out), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Three-word image, streamed at full rate.
    cap_start();
    wr(0, 32'h11223344, 1'b0);
    wr(4, 32'h55667788, 1'b0);
    wr(8, 32'h99AABBCC, 1'b0);
    complete();
    chk("t1_size", int'(image_size_out), 12);
    chk("t1_ready", int'(image_ready_out), 1);
    do_read(0, 0);
    chk("t1_first_valid_latency", int'(first_v <= 2), 1);
    chk("t1_handshakes", hs, 12);
    chk("t1_done_cycle", done_at, 14);
    chk("t1_byte0", int'(got_q[0]), 8'h11);
    chk("t1_byte4", int'(got_q[4]), 8'h55);
    chk("t1_byte11", int'(got_q[11]), 8'hCC);
    ref_q = got_q;

    // Same image with stalls, then a full-rate re-read.
    @(posedge clk); #1;
    do_read(1, 0);
    chk("t2_handshakes", hs, 12);
    for (int i = 0; i < 12; i++) chk("t2_same_stream", int'(got_q[i]), int'(ref_q[i]));
    @(posedge clk); #1;
    do_read(0, 0);
    chk("t2_reread_handshakes", hs, 12);
    for (int i = 0; i < 12; i++) chk("t2_reread_stream", int'(got_q[i]), int'(ref_q[i]));

    // Overflow: word at 16 falls outside a 16-byte buffer.
    @(posedge clk); #1;
    cap_start();
    for (int a = 0; a <= 16; a += 4) wr(a, 32'hA0B0C0D0 + 32'(a), 1'b0);
    @(negedge clk);
    chk("t3_ovf_set", int'(overflow_out), 1);
    complete();
    chk("t3_size", int'(image_size_out), 16);
    @(posedge clk); #1;
    do_read(0, 0);
    chk("t3_handshakes", hs, 16);
    chk("t3_byte15", int'(got_q[15]), 8'hDC);

    // Last word arrives in the same cycle as image_valid.
    @(posedge clk); #1;
    cap_start();
    wr(0, 32'hDEADBEEF, 1'b0);
    wr(4, 32'h0A0B0C0D, 1'b1);
    complete();
    chk("t4_size", int'(image_size_out), 8);
    do_read(0, 0);
    chk("t4_handshakes", hs, 8);
    chk("t4_last_byte", int'(got_q[7]), 8'h0D);

    // Abort a readout after five bytes.
    @(posedge clk); #1;
    cap_start();
    for (int a = 0; a < 16; a += 4) wr(a, 32'h01020304 * 32'(a + 1), 1'b0);
    complete();
    do_read(0, 5);
    @(posedge clk); #1;
    cap_start();
    @(negedge clk);
    chk("t5_valid_low", int'(rd_valid_out), 0);
    chk("t5_ready_low", int'(image_ready_out), 0);
    chk("t5_size_zero", int'(image_size_out), 0);
    chk("t5_ovf_zero", int'(overflow_out), 0);
    for (int k = 0; k < 3; k++) begin
      chk("t5_no_done", int'(rd_done_out), 0);
      @(negedge clk);
    end
    // Still in CAPTURE: completing with no words gives an empty image.
    complete();
    chk("t5_empty_size", int'(image_size_out), 0);
    do_read(0, 0);
    chk("t5_empty_done_cycle", done_at, 1);
    chk("t5_empty_handshakes", hs, 0);

    // Asynchronous reset mid-read; no data accepted until a new capture.
    @(posedge clk); #1;
    cap_start();
    wr(0, 32'h11223344, 1'b0);
    wr(4, 32'h55667788, 1'b0);
    complete();
    do_read(0, 2);
    @(posedge clk);
    #3 rst = 1'b1;
    m_ovf = 1'b0; m_cap = 1'b0; m_hwm = 0;
    #1;
    chk("t6_rst_ready", int'(image_ready_out), 0);
    chk("t6_rst_size", int'(image_size_out), 0);
    chk("t6_rst_valid", int'(rd_valid_out), 0);
    chk("t6_rst_byte", int'(rd_byte_out), 0);
    chk("t6_rst_done", int'(rd_done_out), 0);
    chk("t6_rst_ovf", int'(overflow_out), 0);
    #2 rst = 1'b0;
    rd_ready_in = 1'b0;
    @(posedge clk); #1;
    wr(12, 32'h12345678, 1'b0);
    wr(16, 32'h12345678, 1'b0);
    image_valid_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_idle_no_ready", int'(image_ready_out), 0);
    @(posedge clk); #1 image_valid_in = 1'b0;
    cap_start();
    wr(0, 32'hCAFEF00D, 1'b0);
    complete();
    chk("t6_size", int'(image_size_out), 4);
    do_read(0, 0);
    chk("t6_handshakes", hs, 4);
    chk("t6_byte0", int'(got_q[0]), 8'hCA);
    chk("t6_byte3", int'(got_q[3]), 8'h0D);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
